systolic_array_ctrl: RTL and testbench

Sequencer for the 4x6 FP16 systolic array and its data skew buffer. On a start command it latches a weight set, pulses weight loading into the array, and streams N ifmap vectors in from an upstream valid/ready source. It then tracks each vector through the skew and array pipeline, de-skews the per-column partial sums, and emits one aligned 6-column result per input vector.

---
 rtl/npu_pkg.sv | 26 ++
 rtl/systolic_array_ctrl_psum_deskew.sv | 31 +++
 rtl/systolic_array_ctrl.sv | 115 +++++++++++
 tb/tb_systolic_array_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared constants, lane helpers and sequencer state encoding for the
// 4x6 FP16 systolic array control path.
package npu_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 6;
  localparam int DW   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [DW-1:0] lane_get(input logic [ROWS*DW-1:0] v, input int r);
    return v[r*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] col_get(input logic [COLS*DW-1:0] v, input int c);
    return v[c*DW +: DW];
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_psum_deskew.sv
// Triangular delay network: column c is held for COLS-1-c cycles so every
// column of one vector leaves in the same cycle.
module psum_deskew #(
  parameter int COLS = 6,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS*DW-1:0] psum,
  output logic [COLS*DW-1:0] aligned
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c*DW +: DW] = psum[c*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] pipe [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= psum[c*DW +: DW];
          for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign aligned[c*DW +: DW] = pipe[D-1];
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the systolic array: weight load, ifmap streaming,
// token tracking through skew/array latency, and aligned result output.
module systolic_array_ctrl
  import npu_pkg::*;
#(
  parameter int LAT_BASE = 8,
  parameter int SETTLE   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vec,
  input  logic [ROWS*COLS*DW-1:0]  weights_cfg,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  input  logic [ROWS*DW-1:0]       in_data,
  output logic                     in_ready,
  output logic                     load_en,
  output logic [ROWS*COLS*DW-1:0]  weights_in,
  output logic [ROWS*DW-1:0]       ifmap_raw,
  input  logic [COLS*DW-1:0]       psum_south_out,
  output logic                     out_valid,
  output logic [COLS*DW-1:0]       out_data
);

  // Upstream handshake: a vector transfers on any cycle where in_valid and
  // in_ready are both high; in_ready never depends on in_valid.
  localparam int TOK_D = LAT_BASE + COLS - 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   num_lat, issued, retired;
  logic [SET_W-1:0]   settle_cnt;
  logic               raw_tok;
  logic [TOK_D-1:0]   tok;
  logic [COLS*DW-1:0] aligned;
  logic               accept;

  assign accept = in_valid & in_ready;

  psum_deskew #(.COLS(COLS), .DW(DW)) u_deskew (
    .clk     (clk),
    .rst     (rst),
    .psum    (psum_south_out),
    .aligned (aligned)
  );

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    in_ready  = 1'b0;
    load_en   = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
      ST_LOAD_W: begin
        load_en   = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE - 1))
          state_nxt = (num_lat == '0) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && (issued == num_lat - CNT_W'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  if (retired == num_lat) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // raw_tok travels with ifmap_raw; tok then covers the remaining latency
  // so its last stage lines up with the deskewed columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      num_lat    <= '0;
      issued     <= '0;
      retired    <= '0;
      settle_cnt <= '0;
      weights_in <= '0;
      ifmap_raw  <= '0;
      raw_tok    <= 1'b0;
      tok        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      if (state == ST_IDLE && start) begin
        num_lat    <= num_vec;
        weights_in <= weights_cfg;
        issued     <= '0;
        retired    <= '0;
      end
      ifmap_raw <= accept ? in_data : '0;
      raw_tok   <= accept;
      if (accept) issued <= issued + CNT_W'(1);
      tok       <= {tok[TOK_D-2:0], raw_tok};
      out_valid <= tok[TOK_D-1];
      if (tok[TOK_D-1]) begin
        out_data <= aligned;
        retired  <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed/random bench for systolic_array_ctrl with a behavioural array
// stub and an expected-result queue.
module tb_systolic_array_ctrl;
  import npu_pkg::*;

  localparam int LAT_BASE = 8;
  localparam int SETTLE   = 2;
  localparam int RES_LAT  = LAT_BASE + COLS;

  logic                    clk = 0;
  logic                    rst;
  logic                    start;
  logic [15:0]             num_vec;
  logic [ROWS*COLS*DW-1:0] weights_cfg;
  logic                    busy, done;
  logic                    in_valid;
  logic [ROWS*DW-1:0]      in_data;
  logic                    in_ready, load_en;
  logic [ROWS*COLS*DW-1:0] weights_in;
  logic [ROWS*DW-1:0]      ifmap_raw;
  logic [COLS*DW-1:0]      psum_south_out = '0;
  logic                    out_valid;
  logic [COLS*DW-1:0]      out_data;

  systolic_array_ctrl #(.LAT_BASE(LAT_BASE), .SETTLE(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .weights_cfg(weights_cfg), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_en(load_en), .weights_in(weights_in), .ifmap_raw(ifmap_raw),
    .psum_south_out(psum_south_out), .out_valid(out_valid), .out_data(out_data)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [COLS*DW-1:0] exp_q[$];
  int                 due_q[$];
  int                 last_out_cyc = -1;
  logic [COLS*DW-1:0] last_out_data = '0;

  task automatic check(input string tag, input logic [ROWS*COLS*DW-1:0] obs,
                       input logic [ROWS*COLS*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Array stub: 4 x (2.0 * 1.0) = 8.0 for the unit-weight case, otherwise a
  // column-specific mix so misrouted or mixed columns are visible.
  function automatic logic [DW-1:0] array_col(input logic [ROWS*DW-1:0] x,
                                              input logic [ROWS*COLS*DW-1:0] w,
                                              input int c);
    logic [DW-1:0] acc;
    logic [ROWS*DW-1:0] twos;
    logic [ROWS*COLS*DW-1:0] ones;
    twos = {ROWS{16'h4000}};
    ones = {ROWS*COLS{16'h3C00}};
    if (x == twos && w == ones) return 16'h4800;
    acc = DW'(c * 16'h1357);
    for (int r = 0; r < ROWS; r++)
      acc = {acc[DW-2:0], acc[DW-1]} ^ lane_get(x, r) + w[(r*COLS+c)*DW +: DW];
    return acc;
  endfunction

  function automatic logic [COLS*DW-1:0] ref_result(input logic [ROWS*DW-1:0] x,
                                                    input logic [ROWS*COLS*DW-1:0] w);
    logic [COLS*DW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*DW +: DW] = array_col(x, w, c);
    return r;
  endfunction

  // Column c of whatever ifmap_raw carried in cycle T shows up at T+LAT_BASE+c.
  logic [ROWS*DW-1:0] hist [LAT_BASE+COLS] = '{default: '0};
  always @(negedge clk) begin
    for (int j = LAT_BASE + COLS - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ifmap_raw;
    for (int c = 0; c < COLS; c++)
      psum_south_out[c*DW +: DW] = array_col(hist[LAT_BASE+c], weights_in, c);
  end

  // Result monitor: every out_valid must match the head of the queue at its due cycle.
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("out_valid", out_valid, 1'b1);
      check("out_data", out_data, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else if (out_valid) begin
      check("out_valid_extra", out_valid, 1'b0);
    end
    if (out_valid) begin
      last_out_cyc  = cyc;
      last_out_data = out_data;
    end
  end

  // ---------------- driver ----------------
  // mode 0: back-to-back, 1: toggle 1,0,1,..., 2: random valid
  task automatic run_job(input int num, input int mode, input bit directed,
                         input bit restart_mid, input int rst_at);
    logic [ROWS*COLS*DW-1:0] w;
    logic [ROWS*DW-1:0]      d, prev_d;
    bit                      v, prev_v, got;
    int                      acc, guard, step;
    if (directed) w = {ROWS*COLS{16'h3C00}};
    else for (int i = 0; i < ROWS*COLS*DW/32; i++) w[i*32 +: 32] = $urandom;
    @(negedge clk);
    start = 1; num_vec = 16'(num); weights_cfg = w;
    @(negedge clk);
    start = 0;
    check("load_en_pulse", load_en, 1'b1);
    check("busy_load", busy, 1'b1);
    check("weights_in", weights_in, w);
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      check("settle_load_en", load_en, 1'b0);
      check("settle_in_ready", in_ready, 1'b0);
      check("settle_ifmap", ifmap_raw, '0);
    end
    prev_v = 0; prev_d = '0; acc = 0; guard = 0; step = 0;
    while (acc < num && guard < 1000) begin
      @(negedge clk);
      guard++;
      start = 0;
      check("ifmap_raw", ifmap_raw, prev_v ? prev_d : '0);
      check("in_ready_on", in_ready, 1'b1);
      case (mode)
        0:       v = 1;
        1:       v = (step % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = {$urandom, $urandom};
      if (directed) d = {ROWS{16'h4000}};
      if (restart_mid && acc == 1) begin
        start = 1; num_vec = 16'(num + 5);
      end
      in_valid = v; in_data = d;
      if (v) begin
        exp_q.push_back(ref_result(d, w));
        due_q.push_back(cyc + 1 + RES_LAT);
        acc++;
      end
      prev_v = v; prev_d = d; step++;
    end
    @(negedge clk);
    in_valid = 0; start = 0;
    check("ifmap_raw_last", ifmap_raw, prev_v ? prev_d : '0);
    check("in_ready_off", in_ready, 1'b0);
    if (rst_at > 0) begin
      repeat (rst_at) @(negedge clk);
      rst = 1;
      exp_q.delete(); due_q.delete();
      @(negedge clk);
      rst = 0;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_load_en", load_en, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_ifmap", ifmap_raw, '0);
      check("rst_weights", weights_in, '0);
      check("rst_out_data", out_data, '0);
      for (int i = 0; i < RES_LAT + 10; i++) begin
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_done", done, 1'b0);
      end
      return;
    end
    got = 0; guard = 0;
    while (!got && guard < 200) begin
      if (done) got = 1;
      else begin
        check("drain_in_ready", in_ready, 1'b0);
        check("drain_load_en", load_en, 1'b0);
        @(negedge clk);
        guard++;
      end
    end
    check("done_seen", got, 1'b1);
    check("results_retired", exp_q.size(), 0);
    if (got && num > 0) check("done_after_last", cyc, last_out_cyc + 1);
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("busy_after", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; start = 0; num_vec = '0; weights_cfg = '0; in_valid = 0; in_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_load_en", load_en, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_ifmap", ifmap_raw, '0);
    check("reset_weights", weights_in, '0);
    check("reset_out_data", out_data, '0);
    rst = 0;

    run_job(2, 0, 1, 0, 0);
    check("unit_weight_result", last_out_data, {COLS{16'h4800}});
    run_job(3, 1, 0, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(4, 0, 0, 1, 0);
    run_job(3, 0, 0, 0, 3);
    run_job(5, 0, 0, 0, 0);
    run_job(6, 2, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_job($urandom_range(1, 8), 2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
